gen_stimuli_seq: RTL and testbench

Programmable stimulus sequencer for traffic-light (semafor) state. It replaces the fixed two-phase counter generator with a loadable table of up to DEPTH steps, each holding {state, duration}. It supports one-shot or looping playback with pause and stop control. It sits in the CLP test harness and drives stare_semafor into the display-selection and light-control blocks.

---
 rtl/gen_stimuli_seq_pkg.sv | 24 ++
 rtl/gen_stimuli_seq_table.sv | 38 +++
 rtl/gen_stimuli_seq.sv | 162 ++++++++++++++++
 tb/tb_gen_stimuli_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_stimuli_seq_pkg.sv
// Shared widths, semafor encodings and FSM state codes for the stimulus sequencer.
package gen_stimuli_seq_pkg;

   localparam int STATE_W_DEF = 3;
   localparam int DUR_W_DEF   = 11;
   localparam int DEPTH_DEF   = 8;

   localparam logic [2:0] SEM_OFF         = 3'b000;
   localparam logic [2:0] SEM_ROSU        = 3'b001;
   localparam logic [2:0] SEM_GALBEN      = 3'b010;
   localparam logic [2:0] SEM_VERDE       = 3'b100;
   localparam logic [2:0] SEM_INTERMITENT = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // A playback length is usable only when it selects at least one and at most DEPTH steps.
   function automatic logic len_in_range(input int unsigned len, input int unsigned depth);
      return (len != 0) && (len <= depth);
   endfunction

endpackage

// File: rtl/gen_stimuli_seq_table.sv
// Step table: DEPTH x {state, dur}, synchronous write/clear, two combinational read ports.
// Port A feeds the duration compare of the current step, port B the state of the step being entered.
module seq_table #(
   parameter int STATE_W = 3,
   parameter int DUR_W   = 11,
   parameter int DEPTH   = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [STATE_W-1:0]         i_wstate,
   input  logic [DUR_W-1:0]           i_wdur,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr_a,
   output logic [DUR_W-1:0]           o_dur_a,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr_b,
   output logic [STATE_W-1:0]         o_state_b
);

   logic [STATE_W-1:0] r_state [DEPTH];
   logic [DUR_W-1:0]   r_dur   [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i] <= '0;
            r_dur[i]   <= '0;
         end
      end else if (i_we) begin
         r_state[i_waddr] <= i_wstate;
         r_dur[i_waddr]   <= i_wdur;
      end
   end

   assign o_dur_a   = r_dur[i_raddr_a];
   assign o_state_b = r_state[i_raddr_b];

endmodule

// File: rtl/gen_stimuli_seq.sv
// Programmable semafor stimulus sequencer: plays {state, dur} steps one-shot or looping.
// Output is registered; the first step appears the cycle after start is sampled.
module gen_stimuli_seq
   import gen_stimuli_seq_pkg::*;
#(
   parameter int                   STATE_W    = STATE_W_DEF,
   parameter int                   DUR_W      = DUR_W_DEF,
   parameter int                   DEPTH      = DEPTH_DEF,
   parameter logic [STATE_W-1:0]   IDLE_STATE = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   i_cfg_addr,
   input  logic [STATE_W-1:0]         i_cfg_state,
   input  logic [DUR_W-1:0]           i_cfg_dur,
   input  logic [$clog2(DEPTH):0]     i_seq_len,
   input  logic                       i_loop_en,
   input  logic                       i_start,
   input  logic                       i_pause,
   input  logic                       i_stop,
   output logic [STATE_W-1:0]         o_stare_semafor,
   output logic [$clog2(DEPTH)-1:0]   o_step_idx,
   output logic                       o_step_pulse,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [1:0]         r_state;
   logic [STATE_W-1:0] r_sem;
   logic [AW-1:0]      r_idx;
   logic [DUR_W-1:0]   r_cnt;
   logic               r_pulse;
   logic               r_busy;
   logic               r_done;
   logic [LW-1:0]      r_len;
   logic               r_loop;

   logic [1:0]         w_state_nxt;
   logic [STATE_W-1:0] w_sem_nxt;
   logic [AW-1:0]      w_idx_nxt;
   logic [DUR_W-1:0]   w_cnt_nxt;
   logic               w_pulse_nxt;
   logic               w_done_nxt;
   logic [LW-1:0]      w_len_nxt;
   logic               w_loop_nxt;

   logic               w_tbl_we;
   logic               w_start_ok;
   logic               w_last;
   logic               w_active;
   logic [AW-1:0]      w_adv_idx;
   logic [AW-1:0]      w_rd_addr;
   logic [DUR_W-1:0]   w_dur_cur;
   logic [STATE_W-1:0] w_state_rd;

   assign w_tbl_we   = i_cfg_we && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_active   = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign w_start_ok = i_start && !w_active && len_in_range(int'(i_seq_len), DEPTH);
   assign w_last     = ({1'b0, r_idx} == (r_len - LW'(1)));
   assign w_adv_idx  = r_idx + AW'(1);
   // Step 0 is read both when starting and when wrapping after the last step.
   assign w_rd_addr  = (w_start_ok || w_last) ? '0 : w_adv_idx;

   seq_table #(
      .STATE_W (STATE_W),
      .DUR_W   (DUR_W),
      .DEPTH   (DEPTH)
   ) u_table (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (w_tbl_we),
      .i_waddr   (i_cfg_addr),
      .i_wstate  (i_cfg_state),
      .i_wdur    (i_cfg_dur),
      .i_raddr_a (r_idx),
      .o_dur_a   (w_dur_cur),
      .i_raddr_b (w_rd_addr),
      .o_state_b (w_state_rd)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_sem_nxt   = r_sem;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      w_done_nxt  = r_done;
      w_len_nxt   = r_len;
      w_loop_nxt  = r_loop;

      if (i_stop) begin
         w_state_nxt = ST_IDLE;
         w_sem_nxt   = IDLE_STATE;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
         w_done_nxt  = 1'b0;
      end else if (w_start_ok) begin
         w_state_nxt = ST_RUN;
         w_sem_nxt   = w_state_rd;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
         w_pulse_nxt = 1'b1;
         w_done_nxt  = 1'b0;
         w_len_nxt   = i_seq_len;
         w_loop_nxt  = i_loop_en;
      end else if (w_active) begin
         // Pause is a level: while held nothing advances, and releasing it counts on that edge.
         if (i_pause) begin
            w_state_nxt = ST_PAUSE;
         end else begin
            w_state_nxt = ST_RUN;
            if (r_cnt != w_dur_cur) begin
               w_cnt_nxt = r_cnt + DUR_W'(1);
            end else if (!w_last || r_loop) begin
               w_idx_nxt   = w_last ? '0 : w_adv_idx;
               w_cnt_nxt   = '0;
               w_sem_nxt   = w_state_rd;
               w_pulse_nxt = 1'b1;
            end else begin
               w_state_nxt = ST_DONE;
               w_sem_nxt   = IDLE_STATE;
               w_done_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_sem   <= IDLE_STATE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_len   <= '0;
         r_loop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sem   <= w_sem_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
         r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
         r_done  <= w_done_nxt;
         r_len   <= w_len_nxt;
         r_loop  <= w_loop_nxt;
      end
   end

   assign o_stare_semafor = r_sem;
   assign o_step_idx      = r_idx;
   assign o_step_pulse    = r_pulse;
   assign o_busy          = r_busy;
   assign o_done          = r_done;

endmodule

// File: tb/tb_gen_stimuli_seq.sv
// Directed bench for gen_stimuli_seq: playback, looping, pause, stop, ignored commands, long step, reset.
module tb_gen_stimuli_seq;
   import gen_stimuli_seq_pkg::*;

   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [2:0]    cfg_state = '0;
   logic [10:0]   cfg_dur = '0;
   logic [AW:0]   seq_len = '0;
   logic          loop_en = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          stop = 1'b0;
   logic [2:0]    o_sem;
   logic [AW-1:0] o_idx;
   logic          o_pulse;
   logic          o_busy;
   logic          o_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gen_stimuli_seq dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_cfg_we        (cfg_we),
      .i_cfg_addr      (cfg_addr),
      .i_cfg_state     (cfg_state),
      .i_cfg_dur       (cfg_dur),
      .i_seq_len       (seq_len),
      .i_loop_en       (loop_en),
      .i_start         (start),
      .i_pause         (pause),
      .i_stop          (stop),
      .o_stare_semafor (o_sem),
      .o_step_idx      (o_idx),
      .o_step_pulse    (o_pulse),
      .o_busy          (o_busy),
      .o_done          (o_done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input logic [AW-1:0] a, input logic [2:0] s, input logic [10:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_state = s; cfg_dur = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_seq(input logic [AW:0] len, input logic lp);
      seq_len = len; loop_en = lp; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop;
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++; if (o_sem !== 3'b000) begin errors++; $display("FAIL reset_sem got=%b exp=000", o_sem); end
      checks++; if (o_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", o_idx); end
      checks++; if (o_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", o_pulse); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
   endtask

   task automatic test_oneshot;
      logic [2:0] es;
      logic [AW-1:0] ei;
      int pulses;
      pulses = 0;
      write_entry(3'd0, SEM_ROSU, 11'd4);
      write_entry(3'd1, SEM_GALBEN, 11'd1);
      write_entry(3'd2, SEM_VERDE, 11'd0);
      start_seq(4'd3, 1'b0);
      for (int k = 0; k < 10; k++) begin
         es = (k < 5) ? SEM_ROSU : (k < 7) ? SEM_GALBEN : (k < 8) ? SEM_VERDE : SEM_OFF;
         ei = (k < 5) ? 3'd0 : (k < 7) ? 3'd1 : 3'd2;
         if (o_pulse === 1'b1) pulses++;
         checks++; if (o_sem !== es) begin errors++; $display("FAIL oneshot_sem k=%0d got=%b exp=%b", k, o_sem, es); end
         checks++; if (o_pulse !== (k == 0 || k == 5 || k == 7)) begin errors++; $display("FAIL oneshot_pulse k=%0d got=%b", k, o_pulse); end
         checks++; if (o_done !== (k >= 8)) begin errors++; $display("FAIL oneshot_done k=%0d got=%b", k, o_done); end
         checks++; if (o_busy !== (k < 8)) begin errors++; $display("FAIL oneshot_busy k=%0d got=%b", k, o_busy); end
         if (k < 8) begin
            checks++; if (o_idx !== ei) begin errors++; $display("FAIL oneshot_idx k=%0d got=%0d exp=%0d", k, o_idx, ei); end
         end
         tick();
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL oneshot_pulse_count got=%0d exp=3", pulses); end
   endtask

   task automatic test_loop;
      logic [2:0] es;
      logic [AW-1:0] ei;
      int m;
      int pulses;
      pulses = 0;
      start_seq(4'd3, 1'b1);
      for (int k = 0; k < 24; k++) begin
         m = k % 8;
         es = (m < 5) ? SEM_ROSU : (m < 7) ? SEM_GALBEN : SEM_VERDE;
         ei = (m < 5) ? 3'd0 : (m < 7) ? 3'd1 : 3'd2;
         if (o_pulse === 1'b1) pulses++;
         checks++; if (o_sem !== es) begin errors++; $display("FAIL loop_sem k=%0d got=%b exp=%b", k, o_sem, es); end
         checks++; if (o_idx !== ei) begin errors++; $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, o_idx, ei); end
         checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL loop_done k=%0d got=%b exp=0", k, o_done); end
         tick();
      end
      checks++; if (pulses != 9) begin errors++; $display("FAIL loop_pulse_count got=%0d exp=9", pulses); end
      checks++; if (o_idx !== 3'd0 || o_pulse !== 1'b1 || o_sem !== SEM_ROSU)
         begin errors++; $display("FAIL loop_wrap idx=%0d pulse=%b sem=%b exp 0/1/001", o_idx, o_pulse, o_sem); end
      do_stop();
   endtask

   task automatic test_pause;
      start_seq(4'd3, 1'b0);
      for (int k = 0; k < 9; k++) begin
         if (k < 8) begin
            checks++; if (o_sem !== SEM_ROSU) begin errors++; $display("FAIL pause_sem k=%0d got=%b exp=001", k, o_sem); end
            checks++; if (o_idx !== 3'd0) begin errors++; $display("FAIL pause_idx k=%0d got=%0d exp=0", k, o_idx); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL pause_busy k=%0d got=%b exp=1", k, o_busy); end
            checks++; if (o_pulse !== (k == 0)) begin errors++; $display("FAIL pause_pulse k=%0d got=%b", k, o_pulse); end
         end else begin
            checks++; if (o_sem !== SEM_GALBEN || o_pulse !== 1'b1)
               begin errors++; $display("FAIL pause_resume sem=%b pulse=%b exp 010/1", o_sem, o_pulse); end
         end
         pause = (k >= 2 && k <= 4);
         tick();
      end
      pause = 1'b0;
      do_stop();
   endtask

   task automatic test_stop;
      start_seq(4'd3, 1'b0);
      repeat (5) tick();
      checks++; if (o_sem !== SEM_GALBEN || o_idx !== 3'd1)
         begin errors++; $display("FAIL stop_pre sem=%b idx=%0d exp 010/1", o_sem, o_idx); end
      do_stop();
      checks++; if (o_sem !== 3'b000) begin errors++; $display("FAIL stop_sem got=%b exp=000", o_sem); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=0", o_done); end
      checks++; if (o_idx !== 3'd0) begin errors++; $display("FAIL stop_idx got=%0d exp=0", o_idx); end
      start_seq(4'd3, 1'b0);
      checks++; if (o_sem !== SEM_ROSU || o_pulse !== 1'b1)
         begin errors++; $display("FAIL restart_first sem=%b pulse=%b exp 001/1", o_sem, o_pulse); end
      repeat (5) tick();
      checks++; if (o_sem !== SEM_GALBEN) begin errors++; $display("FAIL restart_step1 got=%b exp=010", o_sem); end
      repeat (2) tick();
      checks++; if (o_sem !== SEM_VERDE) begin errors++; $display("FAIL restart_step2 got=%b exp=100", o_sem); end
      tick();
      checks++; if (o_done !== 1'b1 || o_sem !== 3'b000)
         begin errors++; $display("FAIL restart_done done=%b sem=%b exp 1/000", o_done, o_sem); end
   endtask

   task automatic test_ignored;
      do_stop();
      start_seq(4'd0, 1'b0);
      checks++; if (o_busy !== 1'b0 || o_pulse !== 1'b0 || o_sem !== 3'b000)
         begin errors++; $display("FAIL len0_ignored busy=%b pulse=%b sem=%b exp 0/0/000", o_busy, o_pulse, o_sem); end
      start_seq(4'd9, 1'b0);
      checks++; if (o_busy !== 1'b0 || o_pulse !== 1'b0)
         begin errors++; $display("FAIL len9_ignored busy=%b pulse=%b exp 0/0", o_busy, o_pulse); end
      start_seq(4'd3, 1'b0);
      tick();
      write_entry(3'd0, SEM_INTERMITENT, 11'd0);
      repeat (8) tick();
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL run_write_done got=%b exp=1", o_done); end
      start_seq(4'd3, 1'b0);
      checks++; if (o_sem !== SEM_ROSU) begin errors++; $display("FAIL run_write_state got=%b exp=001", o_sem); end
      repeat (4) tick();
      checks++; if (o_sem !== SEM_ROSU) begin errors++; $display("FAIL run_write_dur got=%b exp=001", o_sem); end
      tick();
      checks++; if (o_sem !== SEM_GALBEN) begin errors++; $display("FAIL run_write_step1 got=%b exp=010", o_sem); end
      do_stop();
      // write and start on the same edge: step 0 still shows the old state, the wrap shows the new one
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_state = SEM_GALBEN; cfg_dur = 11'd4;
      seq_len = 4'd3; loop_en = 1'b1; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      checks++; if (o_sem !== SEM_ROSU) begin errors++; $display("FAIL wr_start_first got=%b exp=001", o_sem); end
      repeat (8) tick();
      checks++; if (o_sem !== SEM_GALBEN || o_idx !== 3'd0 || o_pulse !== 1'b1)
         begin errors++; $display("FAIL wr_start_wrap sem=%b idx=%0d pulse=%b exp 010/0/1", o_sem, o_idx, o_pulse); end
      do_stop();
   endtask

   task automatic test_long_and_reset;
      int n;
      write_entry(3'd0, SEM_VERDE, 11'd2047);
      start_seq(4'd1, 1'b0);
      n = 0;
      while (o_sem === SEM_VERDE && o_busy === 1'b1 && n < 3000) begin
         n++;
         tick();
      end
      checks++; if (n != 2048) begin errors++; $display("FAIL long_hold got=%0d exp=2048", n); end
      checks++; if (o_done !== 1'b1 || o_sem !== 3'b000)
         begin errors++; $display("FAIL long_done done=%b sem=%b exp 1/000", o_done, o_sem); end
      start_seq(4'd1, 1'b0);
      repeat (100) tick();
      checks++; if (o_busy !== 1'b1 || o_sem !== SEM_VERDE)
         begin errors++; $display("FAIL midrun busy=%b sem=%b exp 1/100", o_busy, o_sem); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (o_sem !== 3'b000) begin errors++; $display("FAIL rst_sem got=%b exp=000", o_sem); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0 || o_pulse !== 1'b0 || o_idx !== 3'd0)
         begin errors++; $display("FAIL rst_misc done=%b pulse=%b idx=%0d exp 0/0/0", o_done, o_pulse, o_idx); end
      start_seq(4'd1, 1'b0);
      checks++; if (o_busy !== 1'b1 || o_pulse !== 1'b1 || o_sem !== 3'b000)
         begin errors++; $display("FAIL rst_table_state busy=%b pulse=%b sem=%b exp 1/1/000", o_busy, o_pulse, o_sem); end
      tick();
      checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rst_table_dur done=%b exp=1", o_done); end
   endtask

   initial begin
      #1;
      test_reset();
      test_oneshot();
      test_loop();
      test_pause();
      test_stop();
      test_ignored();
      test_long_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
